decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter FETCH_W, default 2, instructions presented per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, queue entries (power of two, DEPTH >= 2*FETCH_W).
REQ-003 SHALL have parameter width, default 32, instruction/PC width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all entries (mispredict/exception).
REQ-007 SHALL have port fetch_valid  input  FETCH_W  per-lane instruction valid.
REQ-008 SHALL have port fetch_instr  input  FETCH_W x width  raw instructions, lane 0 oldest.
REQ-009 SHALL have port fetch_pc  input  width  PC of lane 0; lane i PC = fetch_pc + 4*i.
REQ-010 SHALL have port fetch_br_pred  input  FETCH_W  per-lane predicted-taken bit.
REQ-011 SHALL have port fetch_ready  output  1  queue accepts a fetch group this cycle.
REQ-012 SHALL have port deq_valid  output  1  head entry valid.
REQ-013 SHALL have port deq_ready  input  1  consumer takes head entry.
REQ-014 SHALL have port deq_out  output  pci_t  decoded head entry.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-016 SHALL decode each lane into pci_t: pc, instruction, opcode [6:0], funct3 [14:12], funct7 [31:25], rs1 [19:15], rs2 [24:20], rd [11:7], sign-extended I/S/B/J immediates, U immediate with 12 zero LSBs.
REQ-017 SHALL set is_br_instr when opcode equals op_br, and additionally jal_instr/jalr_instr flags for op_jal/op_jalr.
REQ-018 SHALL set br_pred from fetch_br_pred for branch/jal/jalr lanes and force 0 for all other lanes.
REQ-019 SHALL drive fetch_ready = 1 when (DEPTH - count) >= FETCH_W, using registered count only.
REQ-020 SHALL enqueue, on a cycle with fetch_ready=1, every lane with fetch_valid=1, compacted in lane order into consecutive slots starting at tail.
REQ-021 SHALL ignore valid lanes when fetch_ready=0 (fetch must hold the group).
REQ-022 SHALL drive deq_valid = (count != 0) and deq_out = decoded entry at head, read from storage (enqueue-to-visible latency 1 cycle).
REQ-023 SHALL advance head by one when deq_valid and deq_ready are both 1.
REQ-024 SHALL support enqueue and dequeue in the same cycle: count_next = count + enq_n - deq_n.
REQ-025 SHALL wrap head/tail modulo DEPTH with $clog2(DEPTH)-bit pointers.
REQ-026 SHALL, on flush, set head=tail=0 and count=0 next cycle, overriding any same-cycle enqueue and dequeue.
REQ-027 SHALL hold deq_out stable while deq_valid=1 and deq_ready=0.
REQ-028 SHALL treat an all-zero fetch_valid with fetch_ready=1 as a no-op.

Reset
REQ-029 SHALL, on rst assertion, immediately clear head, tail, count; deq_valid=0, fetch_ready=1.
REQ-030 SHALL drive deq_out all-zero while count=0; entry storage content need not be reset.

Structure
REQ-031 SHALL place pci_t (including jal_instr/jalr_instr), rv32i_opcode and op_* constants in rv32i_types.
REQ-032 SHALL instantiate FETCH_W copies of a combinational sub-module decoder_lane (instruction, pc, br_pred -> pci_t).
REQ-033 SHALL keep storage, pointers and count in decode_queue; no other sub-modules.

Verification
REQ-034 Reset then fetch lanes {0x00A00093 addi, 0x00208663 beq} at PC 0x60, br_pred=2'b10 -> next cycle count=2, deq_out.pc=0x60, rd=1, i_imm=10, br_pred=0; after one pop pc=0x64, is_br_instr=1, b_imm=12, br_pred=1.
REQ-035 fetch_valid=2'b10 (lane 1 only) at PC 0x100 -> one entry enqueued with pc=0x104; count=1.
REQ-036 Fill with deq_ready=0 until count=7 (DEPTH=8) -> fetch_ready=0; further groups ignored; count stays 7.
REQ-037 Steady state count=4, fetch 2 and pop 1 each cycle over a pointer wrap -> count +1 per cycle, FIFO order preserved across index 7->0.
REQ-038 count=5 with simultaneous fetch group, pop and flush -> next cycle count=0, deq_valid=0, fetch_ready=1.
REQ-039 Assert rst mid-stream between clock edges -> outputs reach reset values before next edge; first post-reset fetch lands at slot 0.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: RV32I opcode encodings and the predecoded queue entry (pci_t)
package rv32i_types;
   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      rv32i_opcode opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] i_imm;
      logic [31:0] s_imm;
      logic [31:0] b_imm;
      logic [31:0] u_imm;
      logic [31:0] j_imm;
      logic        is_br_instr;
      logic        jal_instr;
      logic        jalr_instr;
      logic        br_pred;
   } pci_t;
endpackage

// File: rtl/decoder_lane.sv
// decoder_lane: combinational predecode of one fetch lane into pci_t
// Ports: instr/pc/br_pred in (raw lane), dec out (decoded entry)
module decoder_lane
   import rv32i_types::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic        br_pred,
   output pci_t        dec
);
   always_comb begin
      dec             = '0;
      dec.pc          = pc;
      dec.instr       = instr;
      dec.opcode      = rv32i_opcode'(instr[6:0]);
      dec.funct3      = instr[14:12];
      dec.funct7      = instr[31:25];
      dec.rs1         = instr[19:15];
      dec.rs2         = instr[24:20];
      dec.rd          = instr[11:7];
      dec.i_imm       = {{21{instr[31]}}, instr[30:20]};
      dec.s_imm       = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      dec.b_imm       = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      dec.u_imm       = {instr[31:12], 12'h000};
      dec.j_imm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      dec.is_br_instr = dec.opcode == op_br;
      dec.jal_instr   = dec.opcode == op_jal;
      dec.jalr_instr  = dec.opcode == op_jalr;
      // prediction is only meaningful for control-flow lanes
      dec.br_pred     = br_pred & (dec.is_br_instr | dec.jal_instr | dec.jalr_instr);
   end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: predecoding instruction queue, FETCH_W lanes in, one entry out
// Ports: clk/rst (async high), flush; fetch_valid/instr/pc/br_pred + fetch_ready in;
//        deq_valid/deq_out + deq_ready out; count = occupied entries
module decode_queue
   import rv32i_types::*;
#(
   parameter int FETCH_W = 2,
   parameter int DEPTH   = 8,
   parameter int width   = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [FETCH_W-1:0]             fetch_valid,
   input  logic [FETCH_W-1:0][width-1:0]  fetch_instr,
   input  logic [width-1:0]               fetch_pc,
   input  logic [FETCH_W-1:0]             fetch_br_pred,
   output logic                           fetch_ready,
   output logic                           deq_valid,
   input  logic                           deq_ready,
   output pci_t                           deq_out,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   pci_t          mem [DEPTH];
   pci_t          dec [FETCH_W];
   logic [PW-1:0] head, tail;
   logic [PW-1:0] off [FETCH_W];
   logic [CW-1:0] enq_n;
   logic          deq_n;
   for (genvar g = 0; g < FETCH_W; g++) begin : g_lane
      decoder_lane u_lane (
         .instr   (fetch_instr[g]),
         .pc      (fetch_pc + width'(4*g)),
         .br_pred (fetch_br_pred[g]),
         .dec     (dec[g])
      );
   end
   assign fetch_ready = (CW'(DEPTH) - count) >= CW'(FETCH_W);
   assign deq_valid   = count != '0;
   assign deq_out     = deq_valid ? mem[head] : '0;
   assign deq_n       = deq_valid & deq_ready;
   // off[i] = number of valid lanes older than lane i, which compacts the group
   always_comb begin
      enq_n = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         off[i] = PW'(enq_n);
         enq_n  = enq_n + CW'(fetch_valid[i]);
      end
      enq_n = fetch_ready ? enq_n : '0;
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_W; i++)
         if (fetch_ready && fetch_valid[i] && !flush) mem[tail + off[i]] <= dec[i];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(deq_n);
         tail  <= tail + PW'(enq_n);
         count <= count + enq_n - CW'(deq_n);
      end
   end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed scoreboard bench for decode_queue
module tb_decode_queue;
   import rv32i_types::*;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        bp;
   } exp_t;
   logic             clk = 0;
   logic             rst = 1;
   logic             flush = 0;
   logic [1:0]       fetch_valid = '0;
   logic [1:0][31:0] fetch_instr = '0;
   logic [31:0]      fetch_pc = '0;
   logic [1:0]       fetch_br_pred = '0;
   logic             fetch_ready, deq_valid;
   logic             deq_ready = 0;
   pci_t             deq_out;
   logic [3:0]       count;
   exp_t             sb[$];
   int               checks = 0;
   int               failures = 0;
   int               k = 0;
   decode_queue dut (
      .clk(clk), .rst(rst), .flush(flush), .fetch_valid(fetch_valid),
      .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_br_pred(fetch_br_pred),
      .fetch_ready(fetch_ready), .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_out(deq_out), .count(count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic is_cf(input logic [31:0] ins);
      return ins[6:0] == 7'h63 || ins[6:0] == 7'h6F || ins[6:0] == 7'h67;
   endfunction
   // one clock: drive, check head against scoreboard, update model, advance
   task automatic cyc(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] pc, input logic [1:0] bp, input logic dr, input logic fl);
      logic rdy;
      logic [31:0] ins;
      fetch_valid = fv; fetch_instr[0] = i0; fetch_instr[1] = i1; fetch_pc = pc;
      fetch_br_pred = bp; deq_ready = dr; flush = fl;
      #1;
      rdy = (8 - sb.size()) >= 2;
      chk("fetch_ready", 32'(fetch_ready), 32'(rdy));
      chk("deq_valid", 32'(deq_valid), 32'(sb.size() != 0));
      chk("count", 32'(count), sb.size());
      if (sb.size() != 0) begin
         chk("head_pc", deq_out.pc, sb[0].pc);
         chk("head_instr", deq_out.instr, sb[0].instr);
         chk("head_br_pred", 32'(deq_out.br_pred), 32'(sb[0].bp));
      end
      if (fl) sb.delete();
      else begin
         if (dr && sb.size() != 0) void'(sb.pop_front());
         if (rdy)
            for (int i = 0; i < 2; i++)
               if (fv[i]) begin
                  ins = i ? i1 : i0;
                  sb.push_back('{pc + 32'(4*i), ins, bp[i] & is_cf(ins)});
               end
      end
      @(posedge clk);
      #1;
   endtask
   // filler group with unique instructions/PCs
   task automatic grp(input logic [1:0] fv, input logic dr, input logic fl);
      k++;
      cyc(fv, 32'h00000013 | (32'(k) << 20), 32'h00000093 | (32'(k) << 20),
          32'h1000 + 32'(k) * 8, 2'b00, dr, fl);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #3 rst = 0;
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_deq_valid", 32'(deq_valid), 0);
      chk("rst_fetch_ready", 32'(fetch_ready), 1);
      checks++;
      assert (deq_out === '0) else begin failures++; $error("FAIL rst_deq_out observed=%h expected=0", deq_out); end
      // addi + beq pair
      cyc(2'b11, 32'h00A00093, 32'h00208663, 32'h60, 2'b10, 0, 0);
      chk("t1_count", 32'(count), 2);
      chk("t1_pc", deq_out.pc, 32'h60);
      chk("t1_rd", 32'(deq_out.rd), 1);
      chk("t1_i_imm", deq_out.i_imm, 10);
      chk("t1_br_pred", 32'(deq_out.br_pred), 0);
      chk("t1_opcode", 32'(deq_out.opcode), 32'(op_imm));
      cyc(2'b00, 0, 0, 0, 0, 1, 0);
      chk("t1b_pc", deq_out.pc, 32'h64);
      chk("t1b_is_br", 32'(deq_out.is_br_instr), 1);
      chk("t1b_b_imm", deq_out.b_imm, 12);
      chk("t1b_br_pred", 32'(deq_out.br_pred), 1);
      chk("t1b_rs2", 32'(deq_out.rs2), 2);
      cyc(2'b00, 0, 0, 0, 0, 1, 0);
      checks++;
      assert (deq_out === '0) else begin failures++; $error("FAIL empty_deq_out observed=%h expected=0", deq_out); end
      // lane 1 only: lui
      cyc(2'b10, 32'hFFFFFFFF, 32'h123452B7, 32'h100, 2'b00, 0, 0);
      chk("t2_count", 32'(count), 1);
      chk("t2_pc", deq_out.pc, 32'h104);
      chk("t2_u_imm", deq_out.u_imm, 32'h12345000);
      cyc(2'b00, 0, 0, 0, 0, 1, 0);
      // jal / jalr predicted, store with prediction forced off
      cyc(2'b11, 32'h008000EF, 32'h00008067, 32'h200, 2'b11, 0, 0);
      chk("jal_flag", 32'(deq_out.jal_instr), 1);
      chk("jal_j_imm", deq_out.j_imm, 8);
      chk("jal_br_pred", 32'(deq_out.br_pred), 1);
      cyc(2'b00, 0, 0, 0, 0, 1, 0);
      chk("jalr_flag", 32'(deq_out.jalr_instr), 1);
      chk("jalr_is_br", 32'(deq_out.is_br_instr), 0);
      chk("jalr_br_pred", 32'(deq_out.br_pred), 1);
      cyc(2'b01, 32'hFE20AE23, 0, 32'h300, 2'b01, 1, 0);
      chk("sw_s_imm", deq_out.s_imm, 32'hFFFFFFFC);
      chk("sw_funct3", 32'(deq_out.funct3), 2);
      chk("sw_br_pred", 32'(deq_out.br_pred), 0);
      cyc(2'b00, 0, 0, 0, 0, 1, 0);
      // fill to 7, extra groups ignored
      repeat (3) grp(2'b11, 0, 0);
      grp(2'b01, 0, 0);
      chk("full_fetch_ready", 32'(fetch_ready), 0);
      repeat (2) grp(2'b11, 0, 0);
      chk("full_count", 32'(count), 7);
      // drain to 4, then fetch 2 / pop 1 across the pointer wrap
      repeat (3) grp(2'b00, 1, 0);
      chk("ss_count", 32'(count), 4);
      repeat (3) grp(2'b11, 1, 0);
      chk("ss_count_end", 32'(count), 7);
      repeat (8) grp(2'b00, 1, 0);
      // flush with same-cycle fetch and pop at count 5
      repeat (2) grp(2'b11, 0, 0);
      grp(2'b01, 0, 0);
      chk("pre_flush_count", 32'(count), 5);
      grp(2'b11, 1, 1);
      chk("flush_count", 32'(count), 0);
      chk("flush_deq_valid", 32'(deq_valid), 0);
      chk("flush_fetch_ready", 32'(fetch_ready), 1);
      grp(2'b11, 0, 0);
      grp(2'b00, 1, 0);
      // async reset mid-cycle
      grp(2'b11, 0, 0);
      fetch_valid = '0;
      #2 rst = 1;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_deq_valid", 32'(deq_valid), 0);
      chk("arst_fetch_ready", 32'(fetch_ready), 1);
      #1 rst = 0;
      sb.delete();
      cyc(2'b11, 32'h00500113, 32'h00600193, 32'h400, 2'b00, 0, 0);
      chk("post_rst_pc", deq_out.pc, 32'h400);
      repeat (3) grp(2'b00, 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
